contador_regressivo_2bits: RTL and testbench

CONTADOR_REGRESSIVO_2BITS -- requirements
Module: contador_regressivo_2bits

---
 rtl/contador_regressivo_2bits_pkg.sv | 13 +
 rtl/ff_d_rst_n.sv | 14 +
 rtl/contador_regressivo_2bits.sv | 97 +++++++++
 tb/tb_contador_regressivo_2bits.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/contador_regressivo_2bits_pkg.sv
// Shared definitions for the 2-bit loadable down counter.
package contador_regressivo_2bits_pkg;

    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(0);

endpackage

// File: rtl/ff_d_rst_n.sv
// Single-bit D flip-flop with asynchronous active-low clear.
module ff_d_rst_n (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/contador_regressivo_2bits.sv
// Loadable 2-bit down counter, saturating at 00, built from gate primitives
// and ff_d_rst_n storage cells; busy is the state bit, done a one-cycle pulse.
module contador_regressivo_2bits
    import contador_regressivo_2bits_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] din,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] dec_nx;
    logic [CNT_W-1:0] sel_din;
    logic [CNT_W-1:0] sel_dec;
    logic             state_q;
    logic             state_d;
    logic             done_q;
    logic             done_d;

    logic load_n;
    logic dec;
    logic c0_n;
    logic c1_n;
    logic borrow;
    logic at_one;
    logic term;
    logic term_n;
    logic din_nz;
    logic st_keep;
    logic st_din;
    logic st_hold;

    // Decrement only while counting; IDLE always holds 00 (saturation).
    not  u_load_n (load_n, load);
    and  u_dec    (dec, enable, state_q);
    not  u_c0_n   (c0_n, count_q[0]);
    not  u_c1_n   (c1_n, count_q[1]);
    xor  u_nx0    (dec_nx[0], count_q[0], dec);
    and  u_borrow (borrow, dec, c0_n);
    xor  u_nx1    (dec_nx[1], count_q[1], borrow);

    // Terminal decrement: 01 -> 00 while counting.
    and  u_at_one (at_one, c1_n, count_q[0]);
    and  u_term   (term, dec, at_one);
    not  u_term_n (term_n, term);

    // Per-bit 2:1 load/decrement mux feeding the count flops.
    for (genvar i = 0; i < int'(CNT_W); i++) begin : g_bit
        and u_sel_din (sel_din[i], load, din[i]);
        and u_sel_dec (sel_dec[i], load_n, dec_nx[i]);
        or  u_mux     (count_d[i], sel_din[i], sel_dec[i]);

        ff_d_rst_n u_ff (
            .clk   (clk),
            .rst_n (rst),
            .d     (count_d[i]),
            .q     (count_q[i])
        );
    end

    // Next state: load selects COUNTING for nonzero din; otherwise leave on terminal.
    or   u_din_nz  (din_nz, din[1], din[0]);
    and  u_st_keep (st_keep, state_q, term_n);
    and  u_st_din  (st_din, load, din_nz);
    and  u_st_hold (st_hold, load_n, st_keep);
    or   u_st_mux  (state_d, st_din, st_hold);

    and  u_done_d  (done_d, load_n, term);

    ff_d_rst_n u_state_ff (
        .clk   (clk),
        .rst_n (rst),
        .d     (state_d),
        .q     (state_q)
    );

    ff_d_rst_n u_done_ff (
        .clk   (clk),
        .rst_n (rst),
        .d     (done_d),
        .q     (done_q)
    );

    nor  u_zero (zero, count_q[1], count_q[0]);

    assign count = count_q;
    assign busy  = state_q;
    assign done  = done_q;

endmodule

// File: tb/tb_contador_regressivo_2bits.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_contador_regressivo_2bits;

    logic       clk;
    logic       rst;
    logic       load;
    logic [1:0] din;
    logic       enable;
    logic [1:0] count;
    logic       busy;
    logic       zero;
    logic       done;

    int vectors;
    int miscompares;
    bit chk_en;

    int m_cnt;
    bit m_busy;
    bit m_done;

    contador_regressivo_2bits dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .din    (din),
        .enable (enable),
        .count  (count),
        .busy   (busy),
        .zero   (zero),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt  = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    // Behavioural reference: what one clock edge does to the visible outputs.
    task automatic model_edge(input bit l, input int d, input bit e);
        if (l) begin
            m_cnt  = d;
            m_busy = (d != 0);
            m_done = 1'b0;
        end else if (e && m_busy) begin
            m_cnt  = (m_cnt + 3) % 4;
            m_done = (m_cnt == 0);
            m_busy = (m_cnt != 0);
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic cyc(input bit l, input int d, input bit e);
        load   = l;
        din    = 2'(d);
        enable = e;
        @(posedge clk);
        model_edge(l, d, e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int c, input bit b, input bit dn);
        chk({name, ".count"}, int'(count), c);
        chk({name, ".busy"},  int'(busy), int'(b));
        chk({name, ".done"},  int'(done), int'(dn));
        chk({name, ".zero"},  int'(zero), int'(c == 0));
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (int'(count) != m_cnt || busy != m_busy || done != m_done ||
                zero != (m_cnt == 0)) begin
                miscompares++;
                $display("FAIL model: dut cnt=%0d busy=%0b done=%0b zero=%0b expected cnt=%0d busy=%0b done=%0b zero=%0b",
                         count, busy, done, zero, m_cnt, m_busy, m_done, (m_cnt == 0));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst         = 1'b0;
        load        = 1'b0;
        din         = 2'b00;
        enable      = 1'b0;
        model_reset();

        #2;
        chk_all("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        // Load 11, enable held: 11,10,01,00 with done at 00 only.
        cyc(1'b1, 3, 1'b1); chk_all("dn3_l", 3, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1); chk_all("dn3_a", 2, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1); chk_all("dn3_b", 1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1); chk_all("dn3_c", 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1); chk_all("dn3_d", 0, 1'b0, 1'b0);

        // Load 10, enable 1,0,1: 10,01,01,00.
        cyc(1'b1, 2, 1'b0); chk_all("tog_l", 2, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1); chk_all("tog_a", 1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0); chk_all("tog_b", 1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1); chk_all("tog_c", 0, 1'b0, 1'b1);

        // Idle saturation at 00.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 0, 1'b1); chk_all("sat", 0, 1'b0, 1'b0);
        end

        // Load 00: stays idle, no pulse.
        cyc(1'b1, 0, 1'b1); chk_all("ld0", 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1); chk_all("ld0_b", 0, 1'b0, 1'b0);

        // Load beats a terminal decrement.
        cyc(1'b1, 1, 1'b0); chk_all("win_l", 1, 1'b1, 1'b0);
        cyc(1'b1, 3, 1'b1); chk_all("win", 3, 1'b1, 1'b0);
        cyc(1'b1, 2, 1'b1); chk_all("restart", 2, 1'b1, 1'b0);

        // Asynchronous reset mid-countdown between edges.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 0, 1'b1); chk_all("post_rst", 0, 1'b0, 1'b0);
        end

        // Random traffic checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
